// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// load_store_unit: single-outstanding load/store sequencer between the integer
// pipeline and a req/ack memory port. Formats byte/half/word accesses, flags
// misaligned requests without touching memory, and returns formatted load data.
// alu_op layout: [15:10] funct7 (unused here), [9:7] funct3, [6:0] opcode.
// Optional feature: define LSU_TIMEOUT_EN to add an acknowledge watchdog that
// ends a request after TIMEOUT_CYCLES cycles with fault=1.
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [15:0]             alu_op,
    input  logic [DATA_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   store_data,
    output logic                    busy,
    output logic                    done,
    output logic                    misaligned,
    output logic                    fault,
    output logic [DATA_WIDTH-1:0]   load_data,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    state_t      state, state_next;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        valid_op, mis_in, accept, timeout_hit;
    logic        is_store_q, mis_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, sdata_q;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_fmt;
    logic        unused_ok;

    assign opcode    = alu_op[6:0];
    assign funct3    = alu_op[9:7];
    assign unused_ok = &{1'b0, alu_op[15:10], 32'(TIMEOUT_CYCLES)};

    // Decode whether the presented operation is a memory op and whether it is aligned
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
        valid_op = 1'b0;
        mis_in   = 1'b0;
        if (opcode == OPC_LOAD)
            valid_op = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (opcode == OPC_STORE)
            valid_op = funct3 inside {3'b000, 3'b001, 3'b010};
        case (funct3[1:0])
            2'b01:   mis_in = addr[0];
            2'b10:   mis_in = (addr[1:0] != 2'b00);
            default: mis_in = 1'b0;
        endcase
    end

    assign accept = start && (state == IDLE) && valid_op;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] req_cnt;
    logic             fault_q;

    // Count cycles spent in REQ waiting for the acknowledge
    always_ff @(posedge clk) begin
        if (reset || state != REQ)
            req_cnt <= '0;
        else
            req_cnt <= req_cnt + 1'b1;
    end

    assign timeout_hit = (state == REQ) && !mem_ack && (req_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Remember whether the current operation was ended by the watchdog
    always_ff @(posedge clk) begin
        if (reset || accept)
            fault_q <= 1'b0;
        else if (timeout_hit)
            fault_q <= 1'b1;
    end

    assign fault = (state == DONE) && fault_q;
`else
    assign timeout_hit = 1'b0;
    assign fault       = 1'b0;
`endif

    // Next-state logic: misaligned ops skip the bus and complete immediately
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = mis_in ? DONE : REQ;
            REQ:     if (mem_ack || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and capture of the accepted operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            sdata_q    <= '0;
            mis_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            if (accept) begin
                is_store_q <= (opcode == OPC_STORE);
                funct3_q   <= funct3;
                addr_q     <= addr;
                sdata_q    <= store_data;
                mis_q      <= mis_in;
            end
        end
    end

    // Load result register: updated only when a load is acknowledged
    always_ff @(posedge clk) begin
        if (reset)
            load_data <= '0;
        else if (state == REQ && mem_ack && !is_store_q)
            load_data <= load_fmt;
    end

    // Lane selection and sign/zero extension of the returned word
    always_comb begin
        rd_byte  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_half  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_fmt = {24'h0, rd_byte};
            3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_fmt = {16'h0, rd_half};
            default: load_fmt = mem_rdata;
        endcase
    end

    // Write strobes and lane-replicated write data for stores
    always_comb begin
        mem_wstrb = 4'b0000;
        case (funct3_q[1:0])
            2'b00:   mem_wdata = {4{sdata_q[7:0]}};
            2'b01:   mem_wdata = {2{sdata_q[15:0]}};
            default: mem_wdata = sdata_q;
        endcase
        if (is_store_q) begin
            case (funct3_q[1:0])
                2'b00:   mem_wstrb = 4'b0001 << addr_q[1:0];
                2'b01:   mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                default: mem_wstrb = 4'b1111;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign misaligned = (state == DONE) && mis_q;
    assign mem_req    = (state == REQ);
    assign mem_we     = is_store_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// tb_load_store_unit: directed, hand-computed vectors for load_store_unit.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Define LSU_TIMEOUT_EN to exercise the acknowledge watchdog (TIMEOUT_CYCLES=4).
module tb_load_store_unit;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;
`ifdef LSU_TIMEOUT_EN
    localparam int ACK_WAIT = 3;
`else
    localparam int ACK_WAIT = 5;
`endif

    logic        clk = 1'b0;
    logic        reset, start, mem_ack;
    logic [15:0] alu_op;
    logic [31:0] addr, store_data, mem_rdata;
    logic        busy, done, misaligned, fault, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .addr(addr),
        .store_data(store_data), .busy(busy), .done(done), .misaligned(misaligned),
        .fault(fault), .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    function automatic logic [15:0] ld_op(input logic [2:0] f3);
        return {6'b0, f3, OPC_LOAD};
    endfunction

    function automatic logic [15:0] st_op(input logic [2:0] f3);
        return {6'b0, f3, OPC_STORE};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge, then withdraw it
    task automatic issue(input logic [15:0] op, input logic [31:0] a, input logic [31:0] sd);
        start = 1'b1; alu_op = op; addr = a; store_data = sd;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        start = 0; alu_op = 0; addr = 0; store_data = 0; mem_ack = 0; mem_rdata = 0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_checks++; if ({busy, done, misaligned, fault, mem_req, mem_we} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 000000", {busy, done, misaligned, fault, mem_req, mem_we}); end
        n_checks++; if (mem_wstrb !== 4'b0) begin n_fail++; $display("FAIL reset_wstrb: got %b want 0000", mem_wstrb); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL reset_load_data: got %h want 0", load_data); end
    endtask

    task automatic test_lw_zero_wait();
        mem_rdata = 32'hDEAD_BEEF; mem_ack = 1'b1;   // ack already high in IDLE must be ignored
        issue(ld_op(F_W), 32'h100, 32'h0);
        n_checks++; if ({mem_req, busy, done, mem_we} !== 4'b1100) begin n_fail++; $display("FAIL lw_req_cycle: got %b want 1100", {mem_req, busy, done, mem_we}); end
        n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL lw_mem_addr: got %h want 00000100", mem_addr); end
        n_checks++; if (mem_wstrb !== 4'b0) begin n_fail++; $display("FAIL lw_wstrb: got %b want 0000", mem_wstrb); end
        tick();
        mem_ack = 1'b0;
        n_checks++; if ({done, mem_req, misaligned, busy} !== 4'b1001) begin n_fail++; $display("FAIL lw_done_cycle: got %b want 1001", {done, mem_req, misaligned, busy}); end
        n_checks++; if (load_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_load_data: got %h want deadbeef", load_data); end
        tick();
        n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL lw_back_idle: got %b want 00", {done, busy}); end
    endtask

    task automatic test_subword_loads();
        logic [2:0]  f3  [6];
        logic [31:0] a   [6];
        logic [31:0] rd  [6];
        logic [31:0] exp [6];
        f3  = '{F_B, F_BU, F_H, F_HU, F_B, F_H};
        a   = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
        rd  = '{32'h8000_0000, 32'h8000_0000, 32'h8001_0000, 32'h8001_0000, 32'h0000_7F00, 32'h1234_F00D};
        exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h0000_007F, 32'hFFFF_F00D};
        for (int i = 0; i < 6; i++) begin
            mem_rdata = rd[i]; mem_ack = 1'b1;
            issue(ld_op(f3[i]), a[i], 32'h0);
            tick();
            mem_ack = 1'b0;
            n_checks++; if ({done, load_data} !== {1'b1, exp[i]}) begin n_fail++; $display("FAIL subword_load[%0d]: got done=%b data=%h want done=1 data=%h", i, done, load_data, exp[i]); end
            tick();
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3   [3];
        logic [31:0] a    [3];
        logic [31:0] sd   [3];
        logic [3:0]  strb [3];
        logic [31:0] wd   [3];
        mem_ack = 1'b0;
        issue(st_op(F_H), 32'h202, 32'h1234_ABCD);
        addr = 32'h0; store_data = 32'h0;   // later input changes must not reach the bus
        n_checks++; if ({mem_req, mem_we, mem_wstrb} !== 6'b11_1100) begin n_fail++; $display("FAIL sh_ctrl: got %b want 111100", {mem_req, mem_we, mem_wstrb}); end
        n_checks++; if ({mem_addr, mem_wdata} !== {32'h200, 32'hABCD_ABCD}) begin n_fail++; $display("FAIL sh_bus: got %h/%h want 00000200/abcdabcd", mem_addr, mem_wdata); end
        tick();
        n_checks++; if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h200, 32'hABCD_ABCD}) begin n_fail++; $display("FAIL sh_hold: got %b %h/%h want 1 00000200/abcdabcd", mem_req, mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_checks++; if ({done, load_data} !== {1'b1, 32'hFFFF_F00D}) begin n_fail++; $display("FAIL sh_done_keeps_load: got %b %h want 1 fffff00d", done, load_data); end
        tick();
        f3   = '{F_B, F_W, F_B};
        a    = '{32'h101, 32'h300, 32'h103};
        sd   = '{32'h0000_005A, 32'hCAFE_F00D, 32'h1234_5677};
        strb = '{4'b0010, 4'b1111, 4'b1000};
        wd   = '{32'h5A5A_5A5A, 32'hCAFE_F00D, 32'h7777_7777};
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1;
            issue(st_op(f3[i]), a[i], sd[i]);
            n_checks++; if ({mem_we, mem_wstrb, mem_wdata} !== {1'b1, strb[i], wd[i]}) begin n_fail++; $display("FAIL store[%0d]: got we=%b strb=%b data=%h want we=1 strb=%b data=%h", i, mem_we, mem_wstrb, mem_wdata, strb[i], wd[i]); end
            tick();
            mem_ack = 1'b0;
            tick();
        end
    endtask

    task automatic test_misaligned();
        logic [15:0] op [4];
        logic [31:0] a  [4];
        op = '{ld_op(F_W), ld_op(F_HU), st_op(F_H), st_op(F_W)};
        a  = '{32'h101, 32'h103, 32'h201, 32'h302};
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(op[i], a[i], 32'hFFFF_FFFF);
            n_checks++; if ({mem_req, done, misaligned, busy} !== 4'b0111) begin n_fail++; $display("FAIL misaligned_pulse[%0d]: got %b want 0111", i, {mem_req, done, misaligned, busy}); end
            tick();
            n_checks++; if ({mem_req, done, misaligned, busy} !== 4'b0000) begin n_fail++; $display("FAIL misaligned_end[%0d]: got %b want 0000", i, {mem_req, done, misaligned, busy}); end
        end
    endtask

    task automatic test_invalid_op();
        logic [15:0] op [3];
        op = '{16'b000000_000_0110011, ld_op(3'b011), st_op(3'b100)};
        for (int i = 0; i < 3; i++) begin
            issue(op[i], 32'h100, 32'h0);
            n_checks++; if ({busy, mem_req, done} !== 3'b000) begin n_fail++; $display("FAIL invalid_op[%0d]: got %b want 000", i, {busy, mem_req, done}); end
        end
    endtask

    task automatic test_delayed_ack();
        mem_ack = 1'b0;
        issue(ld_op(F_W), 32'h400, 32'h0);
        for (int i = 0; i < ACK_WAIT; i++) begin
            n_checks++; if ({mem_req, done, fault, mem_addr} !== {3'b100, 32'h400}) begin n_fail++; $display("FAIL wait_cycle[%0d]: got %b %h want 100 00000400", i, {mem_req, done, fault}, mem_addr); end
            if (i == 1) begin
                start = 1'b1; alu_op = st_op(F_W); addr = 32'h500;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        mem_rdata = 32'h1111_2222; mem_ack = 1'b1;
        n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL wait_ack_cycle: got %b %h want 1 00000400", mem_req, mem_addr); end
        tick();
        mem_ack = 1'b0;
        n_checks++; if ({done, fault, load_data} !== {2'b10, 32'h1111_2222}) begin n_fail++; $display("FAIL delayed_done: got %b %h want 10 11112222", {done, fault}, load_data); end
        tick();
        tick();
        n_checks++; if ({busy, mem_req} !== 2'b00) begin n_fail++; $display("FAIL second_start_ignored: got %b want 00", {busy, mem_req}); end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        mem_ack = 1'b0;
        issue(ld_op(F_W), 32'h600, 32'h0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({mem_req, done, fault} !== 3'b100) begin n_fail++; $display("FAIL timeout_wait[%0d]: got %b want 100", i, {mem_req, done, fault}); end
            tick();
        end
        n_checks++; if ({mem_req, done, fault, load_data} !== {3'b011, 32'h1111_2222}) begin n_fail++; $display("FAIL timeout_fault: got %b %h want 011 11112222", {mem_req, done, fault}, load_data); end
        tick();
        n_checks++; if ({busy, done, fault} !== 3'b000) begin n_fail++; $display("FAIL timeout_end: got %b want 000", {busy, done, fault}); end
    endtask
`else
    task automatic test_long_wait();
        mem_ack = 1'b0;
        issue(ld_op(F_W), 32'h600, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        n_checks++; if ({mem_req, done, fault} !== 3'b100) begin n_fail++; $display("FAIL long_wait: got %b want 100", {mem_req, done, fault}); end
        mem_rdata = 32'h1111_2222; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_checks++; if ({done, fault} !== 2'b10) begin n_fail++; $display("FAIL long_wait_done: got %b want 10", {done, fault}); end
        tick();
    endtask
`endif

    task automatic test_back_to_back();
        mem_rdata = 32'hAAAA_0001; mem_ack = 1'b1;
        issue(ld_op(F_W), 32'h800, 32'h0);
        tick();
        n_checks++; if ({done, load_data} !== {1'b1, 32'hAAAA_0001}) begin n_fail++; $display("FAIL b2b_first: got %b %h want 1 aaaa0001", done, load_data); end
        start = 1'b1; alu_op = ld_op(F_W); addr = 32'h804; mem_rdata = 32'hBBBB_0002;
        tick();   // start seen in DONE is ignored; FSM is back in IDLE now
        n_checks++; if ({busy, mem_req} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle: got %b want 00", {busy, mem_req}); end
        tick();
        start = 1'b0;
        n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h804}) begin n_fail++; $display("FAIL b2b_second_req: got %b %h want 1 00000804", mem_req, mem_addr); end
        tick();
        mem_ack = 1'b0;
        n_checks++; if ({done, load_data} !== {1'b1, 32'hBBBB_0002}) begin n_fail++; $display("FAIL b2b_second_done: got %b %h want 1 bbbb0002", done, load_data); end
        tick();
    endtask

    task automatic test_reset_during_req();
        mem_ack = 1'b0;
        issue(ld_op(F_W), 32'h700, 32'h0);
        tick();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req_second_cycle: got %b want 1", mem_req); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({mem_req, busy, done, load_data} !== {3'b000, 32'h0}) begin n_fail++; $display("FAIL rst_in_req: got %b %h want 000 00000000", {mem_req, busy, done}, load_data); end
        mem_rdata = 32'h5555_5555; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_checks++; if ({mem_req, busy, done, load_data} !== {3'b000, 32'h0}) begin n_fail++; $display("FAIL rst_late_ack: got %b %h want 000 00000000", {mem_req, busy, done}, load_data); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_subword_loads();
        test_stores();
        test_misaligned();
        test_invalid_op();
        test_delayed_ack();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_back_to_back();
        test_reset_during_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data and address width; only 32 is supported.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, acknowledge watchdog limit (used only under LSU_TIMEOUT_EN).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  request a memory operation.
REQ-007 SHALL have port alu_op  input  16  {funct7,funct3,opcode}, the same encoding used by the integer ALU.
REQ-008 SHALL have port addr  input  32  effective address, taken from the ALU result.
REQ-009 SHALL have port store_data  input  32  rs2 value for stores.
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port misaligned  output  1  qualifies done; alignment fault.
REQ-013 SHALL have port fault  output  1  qualifies done; bus timeout.
REQ-014 SHALL have port load_data  output  32  formatted load result.
REQ-015 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wstrb out 4, mem_wdata out 32, mem_ack in 1, mem_rdata in 32 (memory side).

Function
REQ-016 SHALL implement FSM states IDLE, REQ, DONE: IDLE->REQ on accepted aligned start; REQ->DONE on mem_ack; IDLE->DONE on accepted misaligned start; DONE->IDLE always.
REQ-017 SHALL accept start only in IDLE with alu_op in {LB,LH,LW,LBU,LHU,SB,SH,SW}; other opcodes and starts while busy are ignored.
REQ-018 SHALL capture alu_op, addr and store_data on acceptance; later input changes have no effect.
REQ-019 SHALL assert busy in REQ and DONE states.
REQ-020 SHALL hold mem_req high for every REQ cycle, starting the cycle after acceptance, and drop it the cycle after mem_ack.
REQ-021 SHALL drive mem_addr as {addr[31:2],2'b00}, constant for the entire request.
REQ-022 SHALL drive mem_wstrb: SB 4'b0001<<addr[1:0]; SH 4'b0011 or 4'b1100 by addr[1]; SW 4'b1111; 0 for loads.
REQ-023 SHALL drive mem_wdata: SB byte replicated x4; SH half replicated x2; SW unmodified.
REQ-024 SHALL register load_data on the mem_ack edge: LB/LBU select the byte at lane addr[1:0] with sign/zero extension; LH/LHU select the half at addr[1] with sign/zero extension; LW passes the full word.
REQ-025 SHALL keep load_data stable until the next load completes; stores leave it unchanged.
REQ-026 SHALL raise done in DONE for exactly one cycle, giving 2-cycle latency from acceptance with zero-wait ack.
REQ-027 SHALL flag misaligned for LH/LHU/SH with addr[0]=1 and for LW/SW with addr[1:0]!=0; the flagged operation issues no mem_req, and done plus misaligned pulse one cycle after acceptance.
REQ-028 SHALL ignore mem_ack outside REQ.
REQ-029 SHALL accept a start in the same cycle the FSM returns to IDLE after DONE (back-to-back spacing of 3 cycles minimum).

Reset
REQ-030 SHALL on reset set state IDLE and busy, done, misaligned, fault, mem_req, mem_we 0; mem_wstrb 0; mem_addr, mem_wdata, load_data 0.
REQ-031 SHALL, on reset during REQ, drop mem_req at that edge with no done pulse; a late mem_ack is ignored.

Configuration
REQ-032 SHALL, with LSU_TIMEOUT_EN defined, count REQ cycles; if TIMEOUT_CYCLES cycles pass without mem_ack, drop mem_req, move to DONE, and pulse done with fault=1, leaving load_data unchanged.
REQ-033 SHALL, without LSU_TIMEOUT_EN, wait indefinitely in REQ, tie fault to 0, and omit the counter.

Verification
REQ-034 Zero-wait LW: start at addr 0x100 with mem_rdata 0xDEADBEEF and ack in the first REQ cycle -> mem_addr 0x100, done 2 cycles after start, load_data 0xDEADBEEF.
REQ-035 LB/LBU at addr 0x103 with mem_rdata 0x80000000 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
REQ-036 SH at addr 0x202 with store_data 0x1234ABCD -> mem_wstrb 4'b1100, mem_wdata 0xABCDABCD, mem_we 1, mem_addr 0x200.
REQ-037 LW at addr 0x101 -> no mem_req; done and misaligned pulse 1 cycle after start.
REQ-038 Ack delayed 5 cycles, with start pulsed again mid-request -> single request, second start ignored; with LSU_TIMEOUT_EN and TIMEOUT_CYCLES 4 and no ack -> fault and done after 4 REQ cycles.
REQ-039 Reset asserted in the 2nd REQ cycle, then ack -> mem_req 0 next cycle, no done, state IDLE.
